// File: rtl/brch_pred_pkg.sv
// Shared types and constants for the tournament branch-predictor update path.
package brch_pred_pkg;

    // Index width baked into the queue entry; the top-level IDX_W must match it.
    localparam int unsigned BRCH_IDX_W = 5;

    // Weakly-not-taken 2-bit counter value.
    localparam logic [1:0] PRED_WEAK_NT = 2'b01;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } upd_ctrl_state_t;

    typedef struct packed {
        logic [BRCH_IDX_W-1:0] idx;
        logic                  pred_global;
        logic                  pred_local;
        logic                  pred_final;
    } brch_q_entry_t;

endpackage

// File: rtl/brch_pred_pend_q.sv
// In-order queue of fetched-but-unresolved predicted branches.
module brch_pred_pend_q
    import brch_pred_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  brch_q_entry_t          push_data_i,
    output brch_q_entry_t          head_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    brch_q_entry_t    mem_q [DEPTH];
    brch_q_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign head_o      = mem_q[head_q];

    // A push into a full queue only fits when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for storage, pointers and count; clear wins over push/pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = push_data_i;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/brch_pred_upd_ctrl.sv
// Branch-predictor table update sequencer: init sweep, per-branch training
// writes, and mispredict squash of wrong-path queue entries.
module brch_pred_upd_ctrl
    import brch_pred_pkg::*;
#(
    parameter int unsigned IDX_W      = BRCH_IDX_W,
    parameter int unsigned DEPTH      = 4,
    parameter logic [1:0]  INIT_STATE = PRED_WEAK_NT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   brch_fetch_vld,
    input  logic [IDX_W-1:0]       brch_fetch_idx,
    input  logic                   pred_global,
    input  logic                   pred_local,
    input  logic                   pred_final,
    input  logic                   resolve_vld,
    input  logic                   resolve_taken,
    input  logic                   hazard_stall,
    output logic                   stall_fetch,
    output logic                   init_busy,
    output logic                   tbl_wr_en,
    output logic [IDX_W-1:0]       tbl_wr_addr,
    output logic                   tbl_wr_init,
    output logic                   upd_taken,
    output logic                   upd_chooser_en,
    output logic                   upd_chooser_global,
    output logic                   mispredict_flush,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   underflow_err
);

    localparam int unsigned ICNT_W = IDX_W + 1;

    if (IDX_W != BRCH_IDX_W) begin : g_idx_w_chk
        $error("IDX_W must equal brch_pred_pkg::BRCH_IDX_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 2");
    end
    // The sweep value must be a weak counter state so first training can flip it.
    if (INIT_STATE != 2'b01 && INIT_STATE != 2'b10) begin : g_init_chk
        $error("INIT_STATE must be a weak counter state");
    end

    upd_ctrl_state_t   state_q, state_d;
    logic [ICNT_W-1:0] init_cnt_q, init_cnt_d;

    logic              q_push, q_pop, q_clr, q_full, q_empty, mispredict;
    brch_q_entry_t     q_head, q_push_data;

    logic              tbl_wr_en_q, tbl_wr_en_d;
    logic [IDX_W-1:0]  tbl_wr_addr_q, tbl_wr_addr_d;
    logic              tbl_wr_init_q, tbl_wr_init_d;
    logic              upd_taken_q, upd_taken_d;
    logic              upd_ch_en_q, upd_ch_en_d;
    logic              upd_ch_glb_q, upd_ch_glb_d;
    logic              flush_q, flush_d;
    logic              init_busy_q, init_busy_d;
    logic              underflow_q, underflow_d;

    // Queue handshakes; the queue is only live in RUN and is frozen by hazard_stall.
    assign q_pop       = (state_q == RUN) & resolve_vld & ~hazard_stall & ~q_empty;
    assign q_push      = (state_q == RUN) & brch_fetch_vld & ~hazard_stall & (~q_full | q_pop);
    assign mispredict  = q_pop & (q_head.pred_final != resolve_taken);
    assign q_clr       = mispredict;
    assign q_push_data = '{idx: brch_fetch_idx, pred_global: pred_global,
                           pred_local: pred_local, pred_final: pred_final};

    brch_pred_pend_q #(
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (q_push),
        .pop_i       (q_pop),
        .clr_i       (q_clr),
        .push_data_i (q_push_data),
        .head_o      (q_head),
        .occupancy_o (occupancy),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep counter advances only in INIT; its extra MSB marks the end of the sweep.
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            init_cnt_d = init_cnt_q + ICNT_W'(1);
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (init_cnt_d[IDX_W]) state_d = RUN;
            RUN:     if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Next values for the registered table-write and status outputs.
    always_comb begin
        tbl_wr_en_d   = 1'b0;
        tbl_wr_addr_d = '0;
        tbl_wr_init_d = 1'b0;
        upd_taken_d   = 1'b0;
        upd_ch_en_d   = 1'b0;
        upd_ch_glb_d  = 1'b0;
        flush_d       = 1'b0;
        init_busy_d   = 1'b0;
        underflow_d   = underflow_q;
        unique case (state_q)
            INIT: begin
                tbl_wr_en_d   = 1'b1;
                tbl_wr_init_d = 1'b1;
                tbl_wr_addr_d = init_cnt_q[IDX_W-1:0];
                init_busy_d   = 1'b1;
            end
            RUN: begin
                if (resolve_vld && !hazard_stall && q_empty) begin
                    underflow_d = 1'b1;
                end
                if (q_pop) begin
                    tbl_wr_en_d   = 1'b1;
                    tbl_wr_addr_d = q_head.idx;
                    upd_taken_d   = resolve_taken;
                    // Chooser trains only when exactly one component was right.
                    upd_ch_en_d   = (q_head.pred_global == resolve_taken) ^
                                    (q_head.pred_local == resolve_taken);
                    upd_ch_glb_d  = (q_head.pred_global == resolve_taken);
                    flush_d       = mispredict;
                end
            end
            default: ;
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q    <= '0;
            tbl_wr_en_q   <= 1'b0;
            tbl_wr_addr_q <= '0;
            tbl_wr_init_q <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_ch_en_q   <= 1'b0;
            upd_ch_glb_q  <= 1'b0;
            flush_q       <= 1'b0;
            init_busy_q   <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            init_cnt_q    <= init_cnt_d;
            tbl_wr_en_q   <= tbl_wr_en_d;
            tbl_wr_addr_q <= tbl_wr_addr_d;
            tbl_wr_init_q <= tbl_wr_init_d;
            upd_taken_q   <= upd_taken_d;
            upd_ch_en_q   <= upd_ch_en_d;
            upd_ch_glb_q  <= upd_ch_glb_d;
            flush_q       <= flush_d;
            init_busy_q   <= init_busy_d;
            underflow_q   <= underflow_d;
        end
    end

    assign tbl_wr_en          = tbl_wr_en_q;
    assign tbl_wr_addr        = tbl_wr_addr_q;
    assign tbl_wr_init        = tbl_wr_init_q;
    assign upd_taken          = upd_taken_q;
    assign upd_chooser_en     = upd_ch_en_q;
    assign upd_chooser_global = upd_ch_glb_q;
    assign mispredict_flush   = flush_q;
    assign init_busy          = init_busy_q;
    assign underflow_err      = underflow_q;
    assign stall_fetch        = init_busy_q | (state_q == FLUSH) | q_full;

endmodule
